// File: rtl/host_mem_responder.sv
// host_mem_responder
// OBI slave terminating the host-memory master port with a word-addressed
// SRAM model, a fixed response latency, an outstanding-request cap and
// read/write access counters.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   obi_req_i/gnt_o      request / combinational grant
//   obi_addr_i           byte address (bits [1:0] ignored)
//   obi_we_i, obi_be_i   write enable, byte enables
//   obi_wdata_i          write data
//   obi_rvalid_o         single-cycle response strobe
//   obi_rdata_o          read data (0 for writes and errored accesses)
//   obi_err_o            out-of-range access, qualified by rvalid
//   stall_i              back-pressure, forces grant low
//   rd_count_o           accepted reads (wrapping)
//   wr_count_o           accepted writes (wrapping)
module host_mem_responder #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    input  logic                    stall_i,
    output logic [31:0]             rd_count_o,
    output logic [31:0]             wr_count_o
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_W = 32;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH_WORDS];

    logic [LATENCY-1:0]                 valid_q, valid_d;
    logic [LATENCY-1:0]                 err_q, err_d;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [OUT_W-1:0]                   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]                   rd_count_q, rd_count_d;
    logic [CNT_W-1:0]                   wr_count_q, wr_count_d;

    logic             accept;
    logic             oor;
    logic [IDX_W-1:0] word_idx;
    logic             unused_addr_lsbs;

    // Byte lane bits carry no meaning for a word-addressed memory.
    assign unused_addr_lsbs = ^obi_addr_i[1:0];

    // Grant is blocked during reset so a request in the reset cycle is dropped.
    assign obi_gnt_o = obi_req_i & ~stall_i & ~rst_i
                     & (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    assign accept    = obi_req_i & obi_gnt_o;
    assign word_idx  = obi_addr_i[IDX_W+1:2];
    // Any address bit above the word index set means address >= 4*depth.
    assign oor       = |obi_addr_i[ADDR_WIDTH-1:IDX_W+2];

    // Response pipeline, outstanding count and counters: next-state logic.
    always_comb begin
        valid_d       = valid_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        outstanding_d = outstanding_q;
        rd_count_d    = rd_count_q;
        wr_count_d    = wr_count_q;

        for (int unsigned i = LATENCY - 1; i > 0; i--) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
        // Stage 0 captures the pre-write word; the array write lands at the same edge.
        valid_d[0] = accept;
        err_d[0]   = accept & oor;
        rdata_d[0] = (accept & ~obi_we_i & ~oor) ? mem_q[word_idx] : '0;

        case ({accept, valid_q[LATENCY-1]})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (accept && !obi_we_i) rd_count_d = rd_count_q + CNT_W'(1);
        if (accept &&  obi_we_i) wr_count_d = wr_count_q + CNT_W'(1);
    end

    // Control state registers; memory contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            err_q         <= '0;
            rdata_q       <= '0;
            outstanding_q <= '0;
            rd_count_q    <= '0;
            wr_count_q    <= '0;
        end else begin
            valid_q       <= valid_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            outstanding_q <= outstanding_d;
            rd_count_q    <= rd_count_d;
            wr_count_q    <= wr_count_d;
        end
    end

    // Byte-masked write of in-range accepted writes.
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (accept && obi_we_i && !oor && obi_be_i[b]) begin
                mem_q[word_idx][b*8 +: 8] <= obi_wdata_i[b*8 +: 8];
            end
        end
    end

    assign obi_rvalid_o = valid_q[LATENCY-1];
    assign obi_err_o    = err_q[LATENCY-1];
    assign obi_rdata_o  = rdata_q[LATENCY-1];
    assign rd_count_o   = rd_count_q;
    assign wr_count_o   = wr_count_q;

endmodule

// File: tb/tb_host_mem_responder.sv
module tb_host_mem_responder;

    localparam int LAT  = 2;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, stall, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        gnt, rvalid, err;
    logic [31:0] rdata, rd_cnt, wr_cnt;

    logic        req1, stall1, we1;
    logic [31:0] addr1, wdata1;
    logic [3:0]  be1;
    logic        gnt1, rvalid1, err1;
    logic [31:0] rdata1, rd_cnt1, wr_cnt1;

    host_mem_responder #(.LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst), .obi_req_i(req), .obi_gnt_o(gnt),
        .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata),
        .obi_rvalid_o(rvalid), .obi_rdata_o(rdata), .obi_err_o(err),
        .stall_i(stall), .rd_count_o(rd_cnt), .wr_count_o(wr_cnt)
    );

    host_mem_responder #(.LATENCY(LAT), .MAX_OUTSTANDING(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .obi_req_i(req1), .obi_gnt_o(gnt1),
        .obi_addr_i(addr1), .obi_we_i(we1), .obi_be_i(be1), .obi_wdata_i(wdata1),
        .obi_rvalid_o(rvalid1), .obi_rdata_o(rdata1), .obi_err_o(err1),
        .stall_i(stall1), .rd_count_o(rd_cnt1), .wr_count_o(wr_cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
        bit          known;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mem_m [int];
    logic [31:0] m_rd, m_wr;
    bit          mon_en = 0;
    int          cyc = 0;

    always @(negedge clk) begin
        bit   exp_gnt, exp_rv, m_oor;
        int   widx;
        rsp_t r, n;
        if (mon_en) begin
            cyc++;
            exp_gnt = req && !stall && !rst && (exp_q.size() < MAXO);
            chk("mon_gnt", 32'(gnt), 32'(exp_gnt));
            exp_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("mon_rvalid", 32'(rvalid), 32'(exp_rv));
            if (exp_rv) begin
                r = exp_q.pop_front();
                chk("mon_err", 32'(err), 32'(r.err));
                if (r.known) chk("mon_rdata", rdata, r.rdata);
            end
            chk("mon_rd_count", rd_cnt, m_rd);
            chk("mon_wr_count", wr_cnt, m_wr);
            if (exp_gnt) begin
                m_oor   = (addr >= 32'h4000);
                widx    = int'(addr / 4) % 4096;
                n.due   = cyc + LAT;
                n.err   = m_oor;
                n.rdata = 32'h0;
                n.known = 1'b1;
                if (we) begin
                    m_wr = m_wr + 32'd1;
                    if (!m_oor) begin
                        if (mem_m.exists(widx)) begin
                            for (int b = 0; b < 4; b++)
                                if (be[b]) mem_m[widx][b*8 +: 8] = wdata[b*8 +: 8];
                        end else if (be == 4'hF) begin
                            mem_m[widx] = wdata;
                        end
                    end
                end else begin
                    m_rd = m_rd + 32'd1;
                    if (!m_oor) begin
                        n.known = mem_m.exists(widx);
                        if (n.known) n.rdata = mem_m[widx];
                    end
                end
                exp_q.push_back(n);
            end
            if (rst) begin
                exp_q.delete();
                m_rd = 32'h0;
                m_wr = 32'h0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
        bit got = 0;
        lat = 1;
        rd  = 32'h0;
        er  = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            if (rvalid) begin
                got = 1;
                rd  = rdata;
                er  = err;
            end else begin
                lat++;
            end
        end
        chk("resp_timeout", 32'(got), 32'd1);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output logic [31:0] rd, output logic er);
        bit granted = 0;
        int t = 0;
        int lat;
        step();
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        while (!granted && t < 50) begin
            @(negedge clk);
            if (gnt) granted = 1;
            t++;
            if (!granted) step();
        end
        chk("issue_gnt", 32'(granted), 32'd1);
        step();
        req = 1'b0;
        wait_resp(rd, er, lat);
        chk("latency", 32'(lat), 32'(LAT));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(logic w, logic [31:0] a, logic [3:0] b, logic [31:0] d,
                                logic [31:0] er_d, logic ee);
        vec_t v;
        v.we = w; v.addr = a; v.be = b; v.wdata = d; v.exp_rdata = er_d; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic        er;
        int          lat, rv_before, next_free;
        bit          exp_g;

        rst = 1'b1; req = 1'b1; stall = 1'b0; we = 1'b0; addr = 32'h0; be = 4'hF; wdata = 32'h0;
        req1 = 1'b0; stall1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; be1 = 4'hF; wdata1 = 32'h0;
        m_rd = 32'h0; m_wr = 32'h0;

        vecs.push_back(mk(1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h10,   4'h2, 32'h0000AA00, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADAAEF, 1'b0));
        vecs.push_back(mk(1'b0, 32'h13,   4'hF, 32'h0,        32'hDEADAAEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h14,   4'hF, 32'h11223344, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 32'h14,   4'h9, 32'hA1B2C3D4, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h14,   4'hF, 32'h0,        32'hA12233D4, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0,    4'hF, 32'h0BADF00D, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 32'h4000, 4'hF, 32'h12345678, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h4000, 4'hF, 32'h0,        32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h0,    4'hF, 32'h0,        32'h0BADF00D, 1'b0));
        vecs.push_back(mk(1'b1, 32'h3FFC, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h3FFC, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0));

        // Reset with a request pending: grant must stay low.
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        step();
        step();
        rst = 1'b0; req = 1'b0; mon_en = 1;
        @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_count", rd_cnt, 32'h0);
        chk("rst_wr_count", wr_cnt, 32'h0);

        // Table-driven single transactions.
        foreach (vecs[i]) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, er);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            if (i == 1) begin
                chk("first_wr_count", wr_cnt, 32'd1);
                chk("first_rd_count", rd_cnt, 32'd1);
            end
        end
        chk("oor_rd_count", rd_cnt, 32'd7);
        chk("oor_wr_count", wr_cnt, 32'd7);

        // Stall: request held for 5 stalled cycles, accepted on release.
        step();
        req = 1'b1; we = 1'b0; addr = 32'h10; stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_gnt", 32'(gnt), 32'd0);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_gnt", 32'(gnt), 32'd1);
        step();
        req = 1'b0;
        wait_resp(rd, er, lat);
        chk("stall_latency", 32'(lat), 32'(LAT));
        chk("stall_rdata", rd, 32'hDEADAAEF);

        // Fill a 64-word region so later reads have known contents.
        for (int i = 0; i < 64; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom(), rd, er);

        // Streaming: 16 back-to-back reads.
        rv_before = 0;
        step();
        for (int i = 0; i < 16 + LAT; i++) begin
            req = (i < 16); we = 1'b0; addr = 32'(i * 4);
            @(negedge clk);
            if (i < 16) chk("stream_gnt", 32'(gnt), 32'd1);
            if (i >= LAT) begin
                chk("stream_rvalid", 32'(rvalid), 32'd1);
                if (rvalid) rv_before++;
            end
            step();
        end
        req = 1'b0;
        chk("stream_pulses", 32'(rv_before), 32'd16);
        repeat (4) step();

        // MAX_OUTSTANDING = 1 instance: a grant only once the slot frees.
        next_free = 0;
        req1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_g = (k >= next_free);
            chk("max1_gnt", 32'(gnt1), 32'(exp_g));
            if (exp_g) next_free = k + LAT + 1;
            step();
        end
        req1 = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req   = ($urandom_range(3) != 0);
            stall = ($urandom_range(4) == 0);
            we    = $urandom_range(1);
            be    = 4'($urandom());
            wdata = $urandom();
            case ($urandom_range(7))
                7:       addr = ($urandom_range(1) != 0) ? 32'h4000 + 32'($urandom_range(255))
                                                         : $urandom();
                default: addr = 32'($urandom_range(255));
            endcase
            step();
        end
        req = 1'b0; stall = 1'b0;
        repeat (8) step();

        // Reset mid-flight: in-flight responses dropped, memory kept.
        issue(1'b1, 32'h20, 4'hF, 32'h5A5A1234, rd, er);
        step();
        req = 1'b1; we = 1'b0; addr = 32'h10;
        @(negedge clk);
        chk("mid_gnt0", 32'(gnt), 32'd1);
        step();
        addr = 32'h14;
        @(negedge clk);
        chk("mid_gnt1", 32'(gnt), 32'd1);
        step();
        req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mid_rvalid", 32'(rvalid), 32'd0);
            chk("mid_rd_count", rd_cnt, 32'h0);
            chk("mid_wr_count", wr_cnt, 32'h0);
            step();
        end
        issue(1'b0, 32'h20, 4'hF, 32'h0, rd, er);
        chk("post_rst_rdata", rd, 32'h5A5A1234);
        chk("post_rst_err", 32'(er), 32'd0);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
